// File: rtl/wl_ctrl_pkg.sv
// Shared types and sizing helpers for the weight-load controller.
package wl_ctrl_pkg;

  typedef enum logic [1:0] {
    WL_IDLE  = 2'd0,
    WL_LOAD  = 2'd1,
    WL_SWAP  = 2'd2,
    WL_DRAIN = 2'd3
  } wl_ctrl_state_e;

  localparam int WL_MESH_WIDTH_DEF = 4;

  // Row counters must hold the value MESH_WIDTH itself, hence the +1.
  function automatic int wl_cnt_width(input int mesh_width);
    return $clog2(mesh_width + 1);
  endfunction

  localparam int WL_CNT_W = wl_cnt_width(WL_MESH_WIDTH_DEF);

endpackage

// File: rtl/wl_ctrl.sv
// Weight-load controller: fetches MESH_WIDTH weight rows, steers them into the
// weight-load stage, then hands the tile to the mesh with a pump/start pulse.
module wl_ctrl
  import wl_ctrl_pkg::*;
#(
  parameter int MESH_WIDTH = WL_MESH_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]         cmd_base_i,
  input  logic [ADDR_WIDTH-1:0]         cmd_stride_i,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic                          mem_rvalid_i,
  output logic [$clog2(MESH_WIDTH)-1:0] wl_ff_counter_o,
  output logic                          wl_rdata_valid_o,
  output logic                          wl_clear_o,
  output logic                          wl_pump_o,
  input  logic                          mesh_ready_i,
  output logic                          mesh_start_o,
  output logic                          busy_o,
  output wl_ctrl_state_e                state_o
);

  localparam int FF_W  = $clog2(MESH_WIDTH);
  localparam int CNT_W = wl_cnt_width(MESH_WIDTH);
  localparam logic [CNT_W-1:0] MW_C = CNT_W'(MESH_WIDTH);

  if (MESH_WIDTH < 2) begin : g_bad_mesh
    $error("wl_ctrl: MESH_WIDTH must be at least 2");
  end

  wl_ctrl_state_e        state_q;
  logic [CNT_W-1:0]      issue_cnt_q;
  logic [CNT_W-1:0]      resp_cnt_q;
  logic [CNT_W-1:0]      out_q;
  logic [CNT_W-1:0]      out_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic                  in_load;
  logic                  gnt_acc;
  logic                  rsp_acc;

  // Handshakes: a transfer happens in a cycle where valid/req and ready/gnt
  // are both high at the rising edge; req and addr hold steady until granted.
  assign in_load          = (state_q == WL_LOAD);
  assign mem_req_o        = in_load && (issue_cnt_q < MW_C);
  assign mem_addr_o       = addr_q;
  assign gnt_acc          = mem_req_o && mem_gnt_i;
  assign rsp_acc          = mem_rvalid_i && (out_q != '0);
  assign cmd_ready_o      = (state_q == WL_IDLE) && !clear_i && !rst_i;
  assign wl_clear_o       = clear_i && !rst_i;
  assign wl_rdata_valid_o = in_load && rsp_acc && !clear_i;
  assign wl_ff_counter_o  = resp_cnt_q[FF_W-1:0];
  assign wl_pump_o        = (state_q == WL_SWAP) && mesh_ready_i && !clear_i;
  assign mesh_start_o     = wl_pump_o;
  assign busy_o           = (state_q != WL_IDLE);
  assign state_o          = state_q;

  // Reads in flight; a stray response with nothing outstanding is dropped.
  always_comb begin
    out_nxt = out_q;
    if (gnt_acc) out_nxt = out_nxt + CNT_W'(1);
    if (rsp_acc) out_nxt = out_nxt - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WL_IDLE;
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
      out_q       <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
    end else if (clear_i) begin
      issue_cnt_q <= '0;
      resp_cnt_q  <= '0;
      out_q       <= out_nxt;
      state_q     <= (out_nxt != '0) ? WL_DRAIN : WL_IDLE;
    end else begin
      out_q <= out_nxt;
      case (state_q)
        WL_IDLE: begin
          if (cmd_valid_i) begin
            addr_q      <= cmd_base_i;
            stride_q    <= cmd_stride_i;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            state_q     <= WL_LOAD;
          end
        end
        WL_LOAD: begin
          // Address accumulates one stride per grant instead of multiplying.
          if (gnt_acc) begin
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            addr_q      <= addr_q + stride_q;
          end
          if (rsp_acc) begin
            resp_cnt_q <= resp_cnt_q + CNT_W'(1);
            if (resp_cnt_q == MW_C - CNT_W'(1)) state_q <= WL_SWAP;
          end
        end
        WL_SWAP: begin
          if (mesh_ready_i) state_q <= WL_IDLE;
        end
        WL_DRAIN: begin
          if (out_nxt == '0) state_q <= WL_IDLE;
        end
        default: state_q <= WL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wl_ctrl.sv
// Directed self-checking bench for wl_ctrl (MESH_WIDTH=4, ADDR_WIDTH=32).
module tb_wl_ctrl;
  import wl_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_i, clear_i, cmd_valid_i, cmd_ready_o;
  logic [31:0] cmd_base_i, cmd_stride_i, mem_addr_o;
  logic mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [1:0] wl_ff_counter_o;
  logic wl_rdata_valid_o, wl_clear_o, wl_pump_o, mesh_ready_i, mesh_start_o, busy_o;
  wl_ctrl_state_e state_o;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_stall[$];
  logic [1:0]  obs_ff[$];
  int          obs_pump[$];
  int          start_bad, swap_bad, swap_low;
  logic        hs_ready, idle_ready, idle_busy;
  bit          done;

  wl_ctrl #(.MESH_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_base_i(cmd_base_i), .cmd_stride_i(cmd_stride_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .wl_ff_counter_o(wl_ff_counter_o),
    .wl_rdata_valid_o(wl_rdata_valid_o), .wl_clear_o(wl_clear_o),
    .wl_pump_o(wl_pump_o), .mesh_ready_i(mesh_ready_i),
    .mesh_start_o(mesh_start_o), .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_i = 0; cmd_valid_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mesh_ready_i = 0;
  endtask

  task automatic handshake(input logic [31:0] base, input logic [31:0] stride);
    cmd_valid_i = 1; cmd_base_i = base; cmd_stride_i = stride;
    #1;
    hs_ready = cmd_ready_o;
    tick();
    cmd_valid_i = 0;
  endtask

  // Runs one tile against a 1-cycle-latency memory; records what it sees.
  task automatic run_tile(input logic [31:0] base, input logic [31:0] stride,
                          input int stall_row, input int stall_len, input int mrdy_delay);
    int grants, resps, post, stall_left;
    logic pend;
    bit seen4;
    obs_addr.delete(); obs_stall.delete(); obs_ff.delete(); obs_pump.delete();
    start_bad = 0; swap_bad = 0; swap_low = 0; done = 0;
    idle_ready = 0; idle_busy = 1;
    grants = 0; resps = 0; post = 0; stall_left = stall_len; seen4 = 0; pend = 0;
    idle_inputs();
    handshake(base, stride);
    for (int k = 1; k <= 60; k++) begin
      mem_rvalid_i = pend;
      mem_gnt_i    = !(grants == stall_row && stall_left > 0);
      mesh_ready_i = seen4 && (post >= mrdy_delay);
      #1;
      pend = mem_req_o && mem_gnt_i;
      if (mem_req_o && mem_gnt_i) begin obs_addr.push_back(mem_addr_o); grants++; end
      if (mem_req_o && !mem_gnt_i) begin obs_stall.push_back(mem_addr_o); stall_left--; end
      if (wl_rdata_valid_o) begin obs_ff.push_back(wl_ff_counter_o); resps++; end
      if (mesh_start_o !== wl_pump_o) start_bad++;
      if (seen4) begin
        if (!mesh_ready_i) begin
          swap_low++;
          if (cmd_ready_o || wl_pump_o || !busy_o) swap_bad++;
        end
        post++;
      end
      if (resps == 4) seen4 = 1;
      if (obs_pump.size() > 0 && !wl_pump_o) begin
        idle_ready = cmd_ready_o; idle_busy = busy_o; done = 1;
        break;
      end
      if (wl_pump_o) obs_pump.push_back(k);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1; clear_i = 1; cmd_valid_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    mesh_ready_i = 1; cmd_base_i = 32'hDEAD_BEEF; cmd_stride_i = 32'h4;
    @(posedge clk); #1;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_o); end
    total++; if (wl_ff_counter_o !== 2'd0) begin bad++; $display("FAIL rst_ff got=%0d exp=0", wl_ff_counter_o); end
    total++; if (wl_rdata_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rdata_valid got=%b exp=0", wl_rdata_valid_o); end
    total++; if (wl_clear_o !== 1'b0) begin bad++; $display("FAIL rst_wl_clear got=%b exp=0", wl_clear_o); end
    total++; if ({wl_pump_o, mesh_start_o, busy_o} !== 3'b000) begin bad++; $display("FAIL rst_pump_start_busy got=%b exp=000", {wl_pump_o, mesh_start_o, busy_o}); end
    tick();
    rst_i = 0; idle_inputs();
    #1;
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready_o); end
    total++; if (state_o !== WL_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state_o, WL_IDLE); end
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] got;
    logic [1:0] gff;
    run_tile(32'h1000, 32'h10, -1, 0, 0);
    exp_q = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
    total++; if (!done) begin bad++; $display("FAIL basic_timeout got=0 exp=1"); end
    total++; if (hs_ready !== 1'b1) begin bad++; $display("FAIL basic_cmd_ready got=%b exp=1", hs_ready); end
    total++; if (obs_addr.size() != 4) begin bad++; $display("FAIL basic_grant_count got=%0d exp=4", obs_addr.size()); end
    foreach (exp_q[i]) begin
      got = (i < obs_addr.size()) ? obs_addr[i] : 'x;
      total++; if (got !== exp_q[i]) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      gff = (i < obs_ff.size()) ? obs_ff[i] : 'x;
      total++; if (gff !== 2'(i)) begin bad++; $display("FAIL basic_ff%0d got=%0d exp=%0d", i, gff, i); end
    end
    total++; if (obs_pump.size() != 1) begin bad++; $display("FAIL basic_pump_count got=%0d exp=1", obs_pump.size()); end
    total++; if (obs_pump.size() < 1 || obs_pump[0] != 6) begin bad++; $display("FAIL basic_pump_cycle got=%0d exp=6", (obs_pump.size() > 0) ? obs_pump[0] : -1); end
    total++; if (start_bad != 0) begin bad++; $display("FAIL basic_start_eq_pump got=%0d exp=0", start_bad); end
    total++; if ({idle_ready, idle_busy} !== 2'b10) begin bad++; $display("FAIL basic_back_idle got=%b exp=10", {idle_ready, idle_busy}); end
  endtask

  task automatic test_stall();
    logic [1:0] gff;
    run_tile(32'h1000, 32'h10, 2, 3, 0);
    exp_q = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
    total++; if (!done) begin bad++; $display("FAIL stall_timeout got=0 exp=1"); end
    total++; if (obs_stall.size() != 3) begin bad++; $display("FAIL stall_len got=%0d exp=3", obs_stall.size()); end
    foreach (obs_stall[i]) begin
      total++; if (obs_stall[i] !== 32'h1020) begin bad++; $display("FAIL stall_addr%0d got=%h exp=00001020", i, obs_stall[i]); end
    end
    total++; if (obs_addr.size() != 4) begin bad++; $display("FAIL stall_grant_count got=%0d exp=4", obs_addr.size()); end
    foreach (exp_q[i]) begin
      total++; if (i >= obs_addr.size() || obs_addr[i] !== exp_q[i]) begin bad++; $display("FAIL stall_addr_seq%0d exp=%h", i, exp_q[i]); end
    end
    total++; if (obs_ff.size() != 4) begin bad++; $display("FAIL stall_resp_count got=%0d exp=4", obs_ff.size()); end
    for (int i = 0; i < 4; i++) begin
      gff = (i < obs_ff.size()) ? obs_ff[i] : 'x;
      total++; if (gff !== 2'(i)) begin bad++; $display("FAIL stall_ff%0d got=%0d exp=%0d", i, gff, i); end
    end
    total++; if (obs_pump.size() != 1 || obs_pump[0] != 9) begin bad++; $display("FAIL stall_pump_cycle got=%0d exp=9", (obs_pump.size() > 0) ? obs_pump[0] : -1); end
  endtask

  task automatic test_swap_hold();
    run_tile(32'h1000, 32'h10, -1, 0, 5);
    total++; if (!done) begin bad++; $display("FAIL swap_timeout got=0 exp=1"); end
    total++; if (swap_low != 5) begin bad++; $display("FAIL swap_low_cycles got=%0d exp=5", swap_low); end
    total++; if (swap_bad != 0) begin bad++; $display("FAIL swap_held got=%0d exp=0", swap_bad); end
    total++; if (obs_pump.size() != 1 || obs_pump[0] != 11) begin bad++; $display("FAIL swap_pump_cycle got=%0d exp=11", (obs_pump.size() > 0) ? obs_pump[0] : -1); end
    total++; if (start_bad != 0) begin bad++; $display("FAIL swap_start_eq_pump got=%0d exp=0", start_bad); end
  endtask

  task automatic test_clear_outstanding();
    int pumps = 0;
    idle_inputs();
    handshake(32'h1000, 32'h10);
    mem_gnt_i = 1; tick();
    mem_gnt_i = 1; tick();
    clear_i = 1; mem_gnt_i = 0;
    #1;
    total++; if (wl_clear_o !== 1'b1) begin bad++; $display("FAIL clr_wl_clear got=%b exp=1", wl_clear_o); end
    total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL clr_cmd_ready got=%b exp=0", cmd_ready_o); end
    tick();
    clear_i = 0; mem_rvalid_i = 1;
    #1;
    total++; if (state_o !== WL_DRAIN) begin bad++; $display("FAIL clr_drain_state got=%0d exp=%0d", state_o, WL_DRAIN); end
    total++; if ({mem_req_o, wl_rdata_valid_o, busy_o} !== 3'b001) begin bad++; $display("FAIL clr_drain_rsp1 got=%b exp=001", {mem_req_o, wl_rdata_valid_o, busy_o}); end
    pumps += wl_pump_o;
    tick();
    #1;
    total++; if ({mem_req_o, wl_rdata_valid_o, busy_o} !== 3'b001) begin bad++; $display("FAIL clr_drain_rsp2 got=%b exp=001", {mem_req_o, wl_rdata_valid_o, busy_o}); end
    pumps += wl_pump_o;
    tick();
    mem_rvalid_i = 0;
    #1;
    total++; if ({cmd_ready_o, busy_o} !== 2'b10) begin bad++; $display("FAIL clr_back_idle got=%b exp=10", {cmd_ready_o, busy_o}); end
    total++; if (pumps != 0) begin bad++; $display("FAIL clr_no_pump got=%0d exp=0", pumps); end
    tick();
  endtask

  task automatic test_clear_grant();
    idle_inputs();
    handshake(32'h1000, 32'h10);
    mem_gnt_i = 1; tick();
    clear_i = 1; mem_gnt_i = 1; tick();
    clear_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    #1;
    total++; if (state_o !== WL_DRAIN) begin bad++; $display("FAIL clrg_drain1 got=%0d exp=%0d", state_o, WL_DRAIN); end
    tick();
    #1;
    total++; if (state_o !== WL_DRAIN) begin bad++; $display("FAIL clrg_drain2 got=%0d exp=%0d", state_o, WL_DRAIN); end
    tick();
    mem_rvalid_i = 0;
    #1;
    total++; if (state_o !== WL_IDLE) begin bad++; $display("FAIL clrg_idle got=%0d exp=%0d", state_o, WL_IDLE); end
    tick();
  endtask

  task automatic test_clear_idle();
    idle_inputs();
    clear_i = 1; cmd_valid_i = 1; cmd_base_i = 32'h5000; cmd_stride_i = 32'h8;
    #1;
    total++; if ({wl_clear_o, cmd_ready_o} !== 2'b10) begin bad++; $display("FAIL clri_outputs got=%b exp=10", {wl_clear_o, cmd_ready_o}); end
    tick();
    idle_inputs();
    #1;
    total++; if ({state_o, busy_o, cmd_ready_o} !== {WL_IDLE, 1'b0, 1'b1}) begin bad++; $display("FAIL clri_stay_idle got=%0d/%b/%b exp=0/0/1", state_o, busy_o, cmd_ready_o); end
    tick();
  endtask

  task automatic test_wrap();
    run_tile(32'hFFFF_FFF0, 32'h10, -1, 0, 0);
    exp_q = '{32'hFFFF_FFF0, 32'h0, 32'h10, 32'h20};
    total++; if (!done) begin bad++; $display("FAIL wrap_timeout got=0 exp=1"); end
    foreach (exp_q[i]) begin
      total++; if (i >= obs_addr.size() || obs_addr[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, (i < obs_addr.size()) ? obs_addr[i] : 32'hx, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    int strays = 0;
    idle_inputs();
    handshake(32'h1000, 32'h10);
    mem_gnt_i = 1; tick();
    mem_gnt_i = 1; mem_rvalid_i = 1; tick();
    mem_gnt_i = 1; mem_rvalid_i = 1; tick();
    rst_i = 1; mesh_ready_i = 1;
    #1;
    total++; if ({mem_req_o, wl_rdata_valid_o, wl_clear_o, wl_pump_o, mesh_start_o, busy_o} !== 6'b0) begin bad++; $display("FAIL rml_ctrl_outputs got=%b exp=000000", {mem_req_o, wl_rdata_valid_o, wl_clear_o, wl_pump_o, mesh_start_o, busy_o}); end
    total++; if ({mem_addr_o, wl_ff_counter_o} !== 34'h0) begin bad++; $display("FAIL rml_addr_ff got=%h/%0d exp=0/0", mem_addr_o, wl_ff_counter_o); end
    tick();
    rst_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (wl_pump_o || mesh_start_o || busy_o || wl_rdata_valid_o) strays++;
      tick();
      mem_rvalid_i = 0;
    end
    total++; if (strays != 0) begin bad++; $display("FAIL rml_no_pump got=%0d exp=0", strays); end
    #1;
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rml_cmd_ready got=%b exp=1", cmd_ready_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    run_tile(32'h2000, 32'h100, -1, 0, 0);
    exp_q = '{32'h2000, 32'h2100, 32'h2200, 32'h2300};
    total++; if (hs_ready !== 1'b1 || obs_pump.size() != 1 || obs_pump[0] != 6) begin bad++; $display("FAIL b2b_first_tile ready=%b pumps=%0d exp=1/1", hs_ready, obs_pump.size()); end
    foreach (exp_q[i]) begin
      total++; if (i >= obs_addr.size() || obs_addr[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_a_addr%0d exp=%h", i, exp_q[i]); end
    end
    run_tile(32'h40, 32'h8, -1, 0, 0);
    exp_q = '{32'h40, 32'h48, 32'h50, 32'h58};
    total++; if (hs_ready !== 1'b1 || obs_pump.size() != 1 || obs_pump[0] != 6) begin bad++; $display("FAIL b2b_second_tile ready=%b pumps=%0d exp=1/1", hs_ready, obs_pump.size()); end
    foreach (exp_q[i]) begin
      total++; if (i >= obs_addr.size() || obs_addr[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_b_addr%0d exp=%h", i, exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_i = 1;
    cmd_base_i = '0; cmd_stride_i = '0;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_swap_hold();
    test_clear_outstanding();
    test_clear_grant();
    test_clear_idle();
    test_wrap();
    test_reset_mid_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wl_ctrl.md
WL_CTRL -- requirements
Module: wl_ctrl

Interface
REQ-001 Parameter MESH_WIDTH, default 4, mesh dimension and number of weight rows per tile; values below 2 SHALL raise an elaboration error.
REQ-002 Parameter ADDR_WIDTH, default 32, width of the weight-memory address.
REQ-003 Port clk_i, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 Port clear_i, input, 1: synchronous flush request.
REQ-006 Port cmd_valid_i / cmd_ready_o, input / output, 1 / 1: tile-load command handshake.
REQ-007 Port cmd_base_i, input, ADDR_WIDTH: address of weight row 0.
REQ-008 Port cmd_stride_i, input, ADDR_WIDTH: byte distance between consecutive rows.
REQ-009 Port mem_req_o / mem_gnt_i, output / input, 1 / 1: memory read request handshake.
REQ-010 Port mem_addr_o, output, ADDR_WIDTH: read address.
REQ-011 Port mem_rvalid_i, input, 1: in-order read response valid, at least 1 cycle after its grant.
REQ-012 Port wl_ff_counter_o, output, $clog2(MESH_WIDTH): column index for the weight-load stage.
REQ-013 Port wl_rdata_valid_o / wl_clear_o / wl_pump_o, output, 1 each: weight-load stage controls.
REQ-014 Port mesh_ready_i / mesh_start_o, input / output, 1 / 1: mesh has released its active buffer / new tile start pulse.
REQ-015 Port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-016 States SHALL be IDLE, LOAD, SWAP and DRAIN.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE with clear_i low; a handshake SHALL latch base and stride, zero issue_cnt and resp_cnt, and enter LOAD.
REQ-018 In LOAD, mem_req_o SHALL be 1 while issue_cnt < MESH_WIDTH, with mem_addr_o = base + issue_cnt*stride, truncated modulo 2^ADDR_WIDTH.
REQ-019 mem_req_o and mem_addr_o SHALL stay stable until granted, and issue_cnt SHALL increment on each mem_req_o & mem_gnt_i.
REQ-020 In LOAD, wl_rdata_valid_o SHALL equal mem_rvalid_i and wl_ff_counter_o SHALL equal resp_cnt; resp_cnt SHALL increment on each mem_rvalid_i.
REQ-021 A grant and a response in the same cycle SHALL both be counted.
REQ-022 When the MESH_WIDTH-th response is accepted, the next state SHALL be SWAP.
REQ-023 In SWAP, the block SHALL wait for mesh_ready_i; in the first cycle it is high, wl_pump_o and mesh_start_o SHALL pulse together for exactly 1 cycle, and the next state SHALL be IDLE.
REQ-024 Latency for a command with zero-wait memory, grant in the same cycle and rvalid 1 cycle later, and mesh_ready_i high: pump at cycle MESH_WIDTH+2 after the handshake cycle.
REQ-025 clear_i SHALL have priority over all other inputs.
REQ-026 While clear_i is high, wl_clear_o SHALL be 1 in the same cycle, and issue_cnt and resp_cnt SHALL be zeroed.
REQ-027 After clear_i, the next state SHALL be DRAIN if outstanding (grants minus responses) is nonzero, otherwise IDLE.
REQ-028 A grant arriving in the clear cycle SHALL be counted as outstanding.
REQ-029 In DRAIN, mem_req_o SHALL be 0 and wl_rdata_valid_o SHALL be 0; each mem_rvalid_i SHALL decrement outstanding, and the state SHALL move to IDLE when outstanding reaches 0.
REQ-030 wl_rdata_valid_o, wl_pump_o and mesh_start_o SHALL be 0 outside LOAD/SWAP.
REQ-031 The outstanding counter SHALL never exceed MESH_WIDTH; a mem_rvalid_i received with outstanding = 0 SHALL be ignored.

Reset
REQ-032 rst_i SHALL force IDLE and zero all counters, base, stride and outstanding.
REQ-033 During reset, every output SHALL be 0 except cmd_ready_o, which SHALL be 1 from the first cycle after deassertion.
REQ-034 Reset mid-LOAD SHALL discard the tile with no pump.

Structure
REQ-035 Package wl_ctrl_pkg SHALL hold the state enum (wl_ctrl_state_e) and the counter-width localparam derived from MESH_WIDTH.
REQ-036 The block SHALL be a single module with no sub-module; the address is formed by an accumulator (base + stride per grant), not a multiplier.

Verification
REQ-037 MESH_WIDTH=4, base=0x1000, stride=0x10, grant always, rvalid 1 cycle later, mesh_ready_i=1 -> addresses 0x1000/0x1010/0x1020/0x1030; wl_ff_counter_o 0,1,2,3 with wl_rdata_valid_o; one pump + mesh_start_o pulse; then IDLE.
REQ-038 mem_gnt_i held low 3 cycles on row 2 -> mem_addr_o stays 0x1020 stable; no duplicate or skipped index.
REQ-039 mesh_ready_i low 5 cycles after the 4th response -> SWAP held, cmd_ready_o=0, pump exactly in the first cycle mesh_ready_i=1.
REQ-040 clear_i with 2 requests outstanding -> wl_clear_o=1 that cycle, DRAIN, next 2 rvalids produce no wl_rdata_valid_o, then IDLE with cmd_ready_o=1.
REQ-041 base=0xFFFFFFF0, stride=0x10 -> addresses wrap to 0x0, 0x10, 0x20 after the first.
REQ-042 rst_i asserted in LOAD after 2 responses -> all outputs 0 immediately; no pump after release.
